// File: rtl/aes_pkg.sv
// Shared AES-128 key-schedule definitions: round count, FSM encoding and round constants.
package aes_pkg;

    localparam int unsigned NUM_ROUNDS = 10;

    typedef enum logic [1:0] {
        StIdle,
        StEmit,
        StDone
    } ke_state_e;

    // Round constant for round r (1..10); anything else yields 0.
    function automatic logic [7:0] rcon(input logic [3:0] r);
        logic [7:0] rc;
        case (r)
            4'd1:    rc = 8'h01;
            4'd2:    rc = 8'h02;
            4'd3:    rc = 8'h04;
            4'd4:    rc = 8'h08;
            4'd5:    rc = 8'h10;
            4'd6:    rc = 8'h20;
            4'd7:    rc = 8'h40;
            4'd8:    rc = 8'h80;
            4'd9:    rc = 8'h1b;
            4'd10:   rc = 8'h36;
            default: rc = 8'h00;
        endcase
        return rc;
    endfunction

endpackage

// File: rtl/aes_sbox.sv
// Combinational AES S-box: multiplicative inverse in GF(2^8) followed by the affine map.
module aes_sbox (
    input  logic [7:0] din,
    output logic [7:0] dout
);

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // x^254 == x^-1 for x != 0, and maps 0 to 0 as the S-box requires.
    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] sq;
        logic [7:0] r;
        sq = gf_mul(x, x);
        r  = 8'h01;
        for (int i = 0; i < 7; i++) begin
            r  = gf_mul(r, sq);
            sq = gf_mul(sq, sq);
        end
        return r;
    endfunction

    logic [7:0] inv;

    always_comb begin
        inv  = gf_inv(din);
        dout = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
             ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    end

endmodule

// File: rtl/key_expand.sv
// AES-128 key expansion streaming one round key per handshake.
// Define KEY_EXPAND_RKBUF_EN to add an 11-entry round-key buffer with a registered read port.
module key_expand
    import aes_pkg::*;
#(
    parameter int unsigned NR = NUM_ROUNDS
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [127:0] key_in,
    output logic         rk_valid,
    input  logic         rk_ready,
    output logic [127:0] rk_data,
    output logic [3:0]   rk_round,
    output logic         busy,
    output logic         done
`ifdef KEY_EXPAND_RKBUF_EN
    ,
    input  logic [3:0]   rd_idx,
    output logic [127:0] rd_key
`endif
);

    localparam logic [3:0] LastRound = 4'(NR);

    ke_state_e    state_q, state_d;
    logic [127:0] key_q, key_d;
    logic [3:0]   round_q, round_d;
    logic [3:0]   round_inc;
    logic [31:0]  rot_w, sub_w, temp_w;
    logic [31:0]  w0n, w1n, w2n, w3n;
    logic         hs;

    assign rot_w = {key_q[23:0], key_q[31:24]};

    for (genvar i = 0; i < 4; i++) begin : g_sbox
        aes_sbox u_sbox (
            .din  (rot_w[8*i +: 8]),
            .dout (sub_w[8*i +: 8])
        );
    end

    assign round_inc = round_q + 4'd1;
    assign temp_w    = sub_w ^ {rcon(round_inc), 24'h000000};
    assign w0n       = key_q[127:96] ^ temp_w;
    assign w1n       = key_q[95:64]  ^ w0n;
    assign w2n       = key_q[63:32]  ^ w1n;
    assign w3n       = key_q[31:0]   ^ w2n;
    assign hs        = (state_q == StEmit) && rk_ready;

    always_comb begin
        state_d = state_q;
        key_d   = key_q;
        round_d = round_q;
        case (state_q)
            StIdle: begin
                if (start) begin
                    key_d   = key_in;
                    round_d = 4'd0;
                    state_d = StEmit;
                end
            end
            StEmit: begin
                if (hs) begin
                    if (round_q == LastRound) begin
                        state_d = StDone;
                    end else begin
                        key_d   = {w0n, w1n, w2n, w3n};
                        round_d = round_inc;
                    end
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            key_q   <= '0;
            round_q <= '0;
        end else begin
            state_q <= state_d;
            key_q   <= key_d;
            round_q <= round_d;
        end
    end

    assign rk_valid = (state_q == StEmit);
    assign busy     = (state_q != StIdle);
    assign done     = (state_q == StDone);
    assign rk_data  = key_q;
    assign rk_round = round_q;

`ifdef KEY_EXPAND_RKBUF_EN
    logic [127:0] rkbuf_q [11];
    logic [127:0] rd_key_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 11; i++) rkbuf_q[i] <= '0;
            rd_key_q <= '0;
        end else begin
            if (hs && (round_q <= 4'd10)) rkbuf_q[round_q] <= key_q;
            rd_key_q <= (rd_idx <= 4'd10) ? rkbuf_q[rd_idx] : '0;
        end
    end

    assign rd_key = rd_key_q;
`endif

endmodule
